// File: rtl/candy_sram_arbiter.sv
// candy_sram_arbiter: shares one SRAM port between instruction fetch and the
// memory stage. Memory stage has fixed priority; each access holds SRAM
// control for ACCESS_CYCLES cycles, then pulses the owner's ready for one cycle.
module candy_sram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [16:0] if_addr,
    output logic        if_ready,
    output logic [23:0] if_rdata,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [16:0] mem_addr,
    input  logic [23:0] mem_wdata,
    output logic        mem_ready,
    output logic [23:0] mem_rdata,

    output logic        busy,

    output logic        sram_ce,
    output logic        sram_oe,
    output logic        sram_we,
    output logic [16:0] sram_addr,
    output logic [23:0] sram_wdata,
    input  logic [23:0] sram_rdata
);

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               owner_mem, owner_mem_d;   // 1: memory stage owns the access
    logic               is_write, is_write_d;

    logic               if_ready_d, mem_ready_d, busy_d;
    logic [DATA_W-1:0]  if_rdata_d, mem_rdata_d;
    logic               sram_ce_d, sram_oe_d, sram_we_d;
    logic [ADDR_W-1:0]  sram_addr_d;
    logic [DATA_W-1:0]  sram_wdata_d;

    // Next-state and next-output logic; every register holds unless changed below
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        owner_mem_d  = owner_mem;
        is_write_d   = is_write;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        if_rdata_d   = if_rdata;
        mem_rdata_d  = mem_rdata;
        sram_ce_d    = sram_ce;
        sram_oe_d    = sram_oe;
        sram_we_d    = sram_we;
        sram_addr_d  = sram_addr;
        sram_wdata_d = sram_wdata;

        case (state)
            IDLE: begin
                if (mem_req) begin
                    state_d     = ACCESS;
                    cnt_d       = CNT_LOAD;
                    owner_mem_d = 1'b1;
                    is_write_d  = mem_we;
                    sram_addr_d = mem_addr;
                    if (mem_we) begin
                        sram_wdata_d = mem_wdata;
                    end
                    sram_ce_d   = 1'b1;
                    sram_oe_d   = ~mem_we;
                    sram_we_d   = mem_we;
                end else if (if_req) begin
                    state_d     = ACCESS;
                    cnt_d       = CNT_LOAD;
                    owner_mem_d = 1'b0;
                    is_write_d  = 1'b0;
                    sram_addr_d = if_addr;
                    sram_ce_d   = 1'b1;
                    sram_oe_d   = 1'b1;
                    sram_we_d   = 1'b0;
                end
            end

            ACCESS: begin
                if (cnt == '0) begin
                    state_d   = RESP;
                    sram_ce_d = 1'b0;
                    sram_oe_d = 1'b0;
                    sram_we_d = 1'b0;
                    if (owner_mem) begin
                        mem_ready_d = 1'b1;
                        if (!is_write) begin
                            mem_rdata_d = sram_rdata;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                    // we falls one cycle early so address/data outlast the we edge
                    if (cnt == CNT_W'(1)) begin
                        sram_we_d = 1'b0;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            owner_mem  <= 1'b0;
            is_write   <= 1'b0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            busy       <= 1'b0;
            sram_ce    <= 1'b0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            owner_mem  <= owner_mem_d;
            is_write   <= is_write_d;
            if_ready   <= if_ready_d;
            mem_ready  <= mem_ready_d;
            if_rdata   <= if_rdata_d;
            mem_rdata  <= mem_rdata_d;
            busy       <= busy_d;
            sram_ce    <= sram_ce_d;
            sram_oe    <= sram_oe_d;
            sram_we    <= sram_we_d;
            sram_addr  <= sram_addr_d;
            sram_wdata <= sram_wdata_d;
        end
    end

endmodule

// File: tb/tb_candy_sram_arbiter.sv
// Bench for candy_sram_arbiter: two lanes (ACCESS_CYCLES = 2 and 4), each with
// its own SRAM pin model, requester agents and a transaction-level reference.
`timescale 1ns/1ps
module tb_candy_sram_arbiter;

    localparam int HIST = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int          at;
        logic        we;
        logic [16:0] addr;
        logic [23:0] wdata;
    } req_t;

    // One comparison: count it, report it when it disagrees
    task automatic check(input string name, input int ln, input int c,
                         input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL lane%0d cyc%0d %s: got %0h expected %0h", ln, c, name, act, want);
        end
    endtask

    // Power-up contents of the SRAM; address 0x10 holds the known pattern
    function automatic logic [23:0] dflt(input logic [16:0] a);
        if (a == 17'h00010) return 24'hA5A5A5;
        return {a[7:0], a[15:0]} ^ 24'h3C96E1 ^ {7'd0, a};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int AC = (g == 0) ? 2 : 4;

        logic        rst;
        logic        if_req, if_ready;
        logic [16:0] if_addr;
        logic [23:0] if_rdata;
        logic        mem_req, mem_we, mem_ready;
        logic [16:0] mem_addr;
        logic [23:0] mem_wdata, mem_rdata;
        logic        busy, sram_ce, sram_oe, sram_we;
        logic [16:0] sram_addr;
        logic [23:0] sram_wdata;
        logic [23:0] sram_rdata = 24'h0;

        candy_sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
            .clk        (clk),
            .rst        (rst),
            .if_req     (if_req),
            .if_addr    (if_addr),
            .if_ready   (if_ready),
            .if_rdata   (if_rdata),
            .mem_req    (mem_req),
            .mem_we     (mem_we),
            .mem_addr   (mem_addr),
            .mem_wdata  (mem_wdata),
            .mem_ready  (mem_ready),
            .mem_rdata  (mem_rdata),
            .busy       (busy),
            .sram_ce    (sram_ce),
            .sram_oe    (sram_oe),
            .sram_we    (sram_we),
            .sram_addr  (sram_addr),
            .sram_wdata (sram_wdata),
            .sram_rdata (sram_rdata)
        );

        int cyc = 0;
        always @(posedge clk) cyc <= cyc + 1;

        // SRAM pins: write-through while ce&we, read data presented while oe
        logic [23:0] sram_arr [int];
        function automatic logic [23:0] sram_peek(input logic [16:0] a);
            return sram_arr.exists(int'(a)) ? sram_arr[int'(a)] : dflt(a);
        endfunction
        always @(posedge clk) if (sram_ce === 1'b1 && sram_we === 1'b1) sram_arr[int'(sram_addr)] = sram_wdata;
        always @(negedge clk) sram_rdata = (sram_oe === 1'b1) ? sram_peek(sram_addr) : 24'h0;

        // Reference: t = cycles since grant (0 idle, 1..AC access, AC+1 ready)
        logic [23:0] ref_mem [int];
        function automatic logic [23:0] ref_peek(input logic [16:0] a);
            return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
        endfunction
        int          t = 0;
        bit          model_live = 0;
        logic        tx_mem = 1'b0, tx_we = 1'b0;
        logic [16:0] tx_addr = 17'h0;
        logic [23:0] tx_wdata = 24'h0;
        logic [23:0] exp_if_rdata = 24'h0, exp_mem_rdata = 24'h0;

        always @(posedge clk) begin
            if (rst === 1'b1) begin
                t = 0;
                exp_if_rdata = 24'h0;
                exp_mem_rdata = 24'h0;
                model_live = 1;
            end else if (model_live) begin
                if (t == 0) begin
                    if (mem_req) begin
                        tx_mem = 1'b1; tx_we = mem_we; tx_addr = mem_addr; tx_wdata = mem_wdata; t = 1;
                    end else if (if_req) begin
                        tx_mem = 1'b0; tx_we = 1'b0; tx_addr = if_addr; t = 1;
                    end
                end else if (t == AC) begin
                    if (tx_we) ref_mem[int'(tx_addr)] = tx_wdata;
                    else if (tx_mem) exp_mem_rdata = ref_peek(tx_addr);
                    else exp_if_rdata = ref_peek(tx_addr);
                    t = AC + 1;
                end else if (t == AC + 1) begin
                    t = 0;
                end else begin
                    t = t + 1;
                end
            end
        end

        // Compare every output against the reference each cycle
        always @(negedge clk) begin
            if (model_live) begin
                check("busy",      g, cyc, 32'(busy),      32'(t != 0));
                check("sram_ce",   g, cyc, 32'(sram_ce),   32'(t >= 1 && t <= AC));
                check("sram_oe",   g, cyc, 32'(sram_oe),   32'(t >= 1 && t <= AC && !tx_we));
                check("sram_we",   g, cyc, 32'(sram_we),   32'(t >= 1 && t <= AC - 1 && tx_we));
                check("if_ready",  g, cyc, 32'(if_ready),  32'(t == AC + 1 && !tx_mem));
                check("mem_ready", g, cyc, 32'(mem_ready), 32'(t == AC + 1 && tx_mem));
                check("if_rdata",  g, cyc, 32'(if_rdata),  32'(exp_if_rdata));
                check("mem_rdata", g, cyc, 32'(mem_rdata), 32'(exp_mem_rdata));
                if (t >= 1 && t <= AC) begin
                    check("sram_addr", g, cyc, 32'(sram_addr), 32'(tx_addr));
                    if (tx_we) check("sram_wdata", g, cyc, 32'(sram_wdata), 32'(tx_wdata));
                end
            end
        end

        // Per-cycle history and ready timestamps for the directed checks
        bit h_busy [HIST];
        bit h_ce   [HIST];
        bit h_oe   [HIST];
        bit h_we   [HIST];
        int          if_rdy_cyc [$];
        logic [23:0] if_rdy_dat [$];
        int          mem_rdy_cyc [$];
        always @(negedge clk) begin
            if (cyc < HIST) begin
                h_busy[cyc] = busy; h_ce[cyc] = sram_ce; h_oe[cyc] = sram_oe; h_we[cyc] = sram_we;
            end
            if (if_ready === 1'b1) begin
                if_rdy_cyc.push_back(cyc);
                if_rdy_dat.push_back(if_rdata);
            end
            if (mem_ready === 1'b1) mem_rdy_cyc.push_back(cyc);
        end

        req_t f_q [$];
        req_t m_q [$];
        int   f_start [$];
        int   m_start [$];
        bit   f_act = 0, m_act = 0;
        bit   done = 0;

        // Fetch requester: hold req until the ready cycle ends (or reset hits)
        initial begin
            req_t r;
            int   k;
            if_req = 1'b0; if_addr = 17'h0;
            forever begin
                @(posedge clk); #1;
                while (f_q.size() != 0 && f_q[0].at <= cyc && rst === 1'b0) begin
                    r = f_q.pop_front();
                    if_addr = r.addr; if_req = 1'b1; f_act = 1; f_start.push_back(cyc);
                    k = 0;
                    do begin @(negedge clk); k++; end while (if_ready !== 1'b1 && rst !== 1'b1 && k < 2000);
                    if (k >= 2000) begin
                        vectors++; miscompares++;
                        $display("FAIL lane%0d fetch_wait: no if_ready after %0d cycles, expected one", g, k);
                    end
                    @(posedge clk); #1;
                    if_req = 1'b0; if_addr = 17'($urandom); f_act = 0;
                end
            end
        end

        // Memory-stage requester, same handshake
        initial begin
            req_t r;
            int   k;
            mem_req = 1'b0; mem_we = 1'b0; mem_addr = 17'h0; mem_wdata = 24'h0;
            forever begin
                @(posedge clk); #1;
                while (m_q.size() != 0 && m_q[0].at <= cyc && rst === 1'b0) begin
                    r = m_q.pop_front();
                    mem_we = r.we; mem_addr = r.addr; mem_wdata = r.wdata; mem_req = 1'b1;
                    m_act = 1; m_start.push_back(cyc);
                    k = 0;
                    do begin @(negedge clk); k++; end while (mem_ready !== 1'b1 && rst !== 1'b1 && k < 2000);
                    if (k >= 2000) begin
                        vectors++; miscompares++;
                        $display("FAIL lane%0d mem_wait: no mem_ready after %0d cycles, expected one", g, k);
                    end
                    @(posedge clk); #1;
                    mem_req = 1'b0; mem_we = 1'($urandom); mem_addr = 17'($urandom);
                    mem_wdata = 24'($urandom); m_act = 0;
                end
            end
        end

        task automatic wait_idle(input int budget);
            int k;
            for (k = 0; k < budget; k++) begin
                @(negedge clk);
                if (f_q.size() == 0 && m_q.size() == 0 && !f_act && !m_act && busy === 1'b0) break;
            end
            if (k >= budget) begin
                vectors++; miscompares++;
                $display("FAIL lane%0d idle_wait: still busy after %0d cycles, expected idle", g, k);
            end
        endtask

        // Directed scenarios with hand-computed timing, then random traffic
        initial begin
            int fi, mi, fs, ms, st, k;
            rst = 1'b1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("rst_sram_addr",  g, cyc, 32'(sram_addr),  32'h0);
            check("rst_sram_wdata", g, cyc, 32'(sram_wdata), 32'h0);
            check("rst_if_rdata",   g, cyc, 32'(if_rdata),   32'h0);
            check("rst_ctrl",       g, cyc, 32'({sram_ce, sram_oe, sram_we, busy, if_ready, mem_ready}), 32'h0);
            @(posedge clk); #1;
            rst = 1'b0;

            // Fetch read of 0x10
            fi = if_rdy_cyc.size(); fs = f_start.size();
            f_q.push_back('{cyc + 2, 1'b0, 17'h00010, 24'h0});
            wait_idle(200);
            st = f_start[fs];
            check("fetch_latency", g, st, if_rdy_cyc[fi] - st, AC + 1);
            check("fetch_data",    g, st, 32'(if_rdy_dat[fi]), 32'hA5A5A5);
            for (int c = 1; c <= AC; c++) check("fetch_ce_oe", g, st + c, 32'({h_ce[st + c], h_oe[st + c]}), 32'h3);
            check("fetch_ce_off",  g, st, 32'(h_ce[st + AC + 1]), 32'h0);
            check("fetch_busy_off", g, st, 32'(h_busy[st + AC + 2]), 32'h0);

            // Memory write to the top address
            mi = mem_rdy_cyc.size(); ms = m_start.size();
            m_q.push_back('{cyc + 2, 1'b1, 17'h1FFFF, 24'h123456});
            wait_idle(200);
            st = m_start[ms];
            check("write_latency", g, st, mem_rdy_cyc[mi] - st, AC + 1);
            check("write_we_on",   g, st, 32'(h_we[st + 1]), 32'h1);
            check("write_we_off",  g, st, 32'(h_we[st + AC]), 32'h0);
            check("write_rdata_kept", g, st, 32'(mem_rdata), 32'h0);

            // Both requests in the same cycle: memory first
            fi = if_rdy_cyc.size(); mi = mem_rdy_cyc.size(); fs = f_start.size(); ms = m_start.size();
            k = cyc + 2;
            m_q.push_back('{k, 1'b0, 17'h00200, 24'h0});
            f_q.push_back('{k, 1'b0, 17'h00055, 24'h0});
            wait_idle(200);
            st = m_start[ms];
            check("simul_same_start", g, st, f_start[fs], st);
            check("simul_mem_lat",    g, st, mem_rdy_cyc[mi] - st, AC + 1);
            check("simul_if_lat",     g, st, if_rdy_cyc[fi] - st, 2 * AC + 3);
            check("simul_if_data",    g, st, 32'(if_rdy_dat[fi]), 32'(dflt(17'h00055)));
            check("simul_mem_data",   g, st, 32'(mem_rdata), 32'(dflt(17'h00200)));

            // Back-to-back fetches at 0, 1, 2
            fi = if_rdy_cyc.size();
            k = cyc + 2;
            for (int a = 0; a < 3; a++) f_q.push_back('{k, 1'b0, 17'(a), 24'h0});
            wait_idle(200);
            for (int a = 0; a < 3; a++) begin
                check("b2b_data", g, if_rdy_cyc[fi + a], 32'(if_rdy_dat[fi + a]), 32'(dflt(17'(a))));
                if (a > 0) check("b2b_spacing", g, if_rdy_cyc[fi + a], if_rdy_cyc[fi + a] - if_rdy_cyc[fi + a - 1], AC + 2);
            end

            // Reset during the first ACCESS cycle of a write
            mi = mem_rdy_cyc.size(); ms = m_start.size();
            m_q.push_back('{cyc + 2, 1'b1, 17'h0BEEF, 24'hDEAD01});
            for (k = 0; k < 50; k++) begin
                @(negedge clk);
                if (m_start.size() > ms) break;
            end
            st = m_start[ms];
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            wait_idle(200);
            check("rst_mid_we_before", g, st, 32'(h_we[st + 1]), 32'h1);
            check("rst_mid_ctrl_off",  g, st, 32'({h_ce[st + 2], h_we[st + 2], h_busy[st + 2]}), 32'h0);
            check("rst_mid_no_ready",  g, st, mem_rdy_cyc.size() - mi, 0);
            fi = if_rdy_cyc.size(); fs = f_start.size();
            f_q.push_back('{cyc + 2, 1'b0, 17'h00020, 24'h0});
            wait_idle(200);
            st = f_start[fs];
            check("post_rst_latency", g, st, if_rdy_cyc[fi] - st, AC + 1);
            check("post_rst_data",    g, st, 32'(if_rdy_dat[fi]), 32'(dflt(17'h00020)));

            // Fetch request rising during a memory ACCESS waits for the next IDLE
            fi = if_rdy_cyc.size(); mi = mem_rdy_cyc.size();
            k = cyc + 2;
            m_q.push_back('{k, 1'b0, 17'h00033, 24'h0});
            f_q.push_back('{k + 1, 1'b0, 17'h00044, 24'h0});
            wait_idle(200);
            check("late_fetch_gap", g, if_rdy_cyc[fi], if_rdy_cyc[fi] - mem_rdy_cyc[mi], AC + 2);

            // Random mixed traffic over a small address window
            for (int n = 0; n < 60; n++) begin
                req_t r;
                r.at    = cyc + int'($urandom_range(0, 6));
                r.we    = 1'($urandom);
                r.addr  = 17'($urandom_range(0, 63));
                r.wdata = 24'($urandom);
                if ($urandom_range(0, 1) == 0) begin
                    r.we = 1'b0;
                    f_q.push_back(r);
                end else begin
                    m_q.push_back(r);
                end
                if ($urandom_range(0, 3) == 0) wait_idle(3000);
            end
            wait_idle(5000);
            done = 1;
        end
    end

    // Wait for both lanes, then report
    initial begin
        int k;
        for (k = 0; k < 40000; k++) begin
            @(posedge clk);
            if (lane[0].done && lane[1].done) break;
        end
        if (k >= 40000) begin
            vectors++; miscompares++;
            $display("FAIL global_timeout: lanes not finished after %0d cycles", k);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/candy_sram_arbiter.md
# candy_sram_arbiter

Shares the single off-chip SRAM port (17-bit address, 24-bit data) between the instruction-fetch stage and the memory stage. Each requester holds a level request until it receives a one-cycle ready pulse. The arbiter grants fixed priority to the memory stage, sequences a multi-cycle SRAM read or write, and returns read data. It sits between the pipeline stages and the SRAM pad interface.

## Interface
- ACCESS_CYCLES, 2, number of cycles SRAM control/address is held per access (legal range 2..15)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch read request, level, held until if_ready
- if_addr  in  17  fetch address, stable while if_req high
- if_ready  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  24  fetched instruction word
- mem_req  in  1  memory-stage request, level, held until mem_ready
- mem_we  in  1  1 = write, 0 = read; stable while mem_req high
- mem_addr  in  17  memory-stage address
- mem_wdata  in  24  write data
- mem_ready  out  1  one-cycle pulse, access complete (mem_rdata valid on reads)
- mem_rdata  out  24  load data
- busy  out  1  high in any state other than IDLE
- sram_ce  out  1  chip enable, active-high
- sram_oe  out  1  output enable (reads)
- sram_we  out  1  write enable
- sram_addr  out  17  SRAM address
- sram_wdata  out  24  data driven to SRAM
- sram_rdata  in  24  data from SRAM

## Operation
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE: the arbiter samples requests.
  - mem_req high: grant mem. mem wins over if_req when both are high in the same cycle.
  - else if_req high: grant fetch.
  - else stay in IDLE.
- On grant, at the next edge:
  - Load sram_addr, sram_wdata (mem writes only), and the owner/we latch.
  - Set sram_ce=1.
  - Reads: sram_oe=1, sram_we=0. Writes: sram_we=1, sram_oe=0.
  - Load a countdown counter with ACCESS_CYCLES-1. Enter ACCESS.
- ACCESS: address, data and ce are held constant for ACCESS_CYCLES cycles; the counter decrements each cycle.
  - Writes: sram_we drops to 0 on the final ACCESS cycle, giving address/data hold past the we edge.
  - On the final ACCESS cycle (counter==0), reads capture sram_rdata into the owner's rdata register at the closing edge.
  - At that edge: ce, oe and we are deasserted, the owner's ready is set, and the FSM enters RESP.
- RESP: the owner's ready is high for exactly one cycle. Requests are ignored here. Return to IDLE.
  - Requesters drop or change req at the edge that ends the ready cycle, so no request is re-issued.
- Write access: mem_rdata is left unchanged.
- if_rdata and mem_rdata hold their value until the next completed read of the same requester.
- No starvation guard: continuous mem_req starves fetch. This is acceptable because the pipeline stalls fetch behind mem.

## Timing
- Reset values: all outputs 0, FSM=IDLE, counter=0, rdata registers 0.
- Reset mid-access: at the reset edge, ce/oe/we are forced to 0, no ready pulse is issued, and the FSM goes to IDLE. An interrupted write is considered lost.
- Latency, with request high in IDLE cycle 0:
  - SRAM control asserted in cycles 1..ACCESS_CYCLES.
  - ready high in cycle ACCESS_CYCLES+1.
  - Next grant possible in cycle ACCESS_CYCLES+2.
  - Throughput: one access per ACCESS_CYCLES+2 cycles.
- A request that rises while the arbiter is in ACCESS or RESP waits and is evaluated in the next IDLE cycle.
- A request dropped by the requester before ready is a protocol violation. Behaviour after a grant: the access still completes and ready still pulses.
- if_ready and mem_ready are never high in the same cycle.

## Test plan
- Fetch read, ACCESS_CYCLES=2, if_addr=17'h00010, SRAM returns 24'hA5A5A5:
  - sram_ce/oe high in cycles 1-2.
  - if_ready pulses in cycle 3 with if_rdata=24'hA5A5A5.
  - busy is low again in cycle 4.
- Mem write to 17'h1FFFF with data 24'h123456:
  - sram_we high in cycle 1 only; addr/data held in cycles 1-2.
  - mem_ready pulses in cycle 3; mem_rdata unchanged.
- Simultaneous if_req and mem_req (read 17'h00200):
  - mem is served first; mem_ready in cycle 3.
  - Fetch is granted in IDLE cycle 4; if_ready in cycle 7.
- Back-to-back fetches at addresses 0, 1, 2 with ACCESS_CYCLES=4:
  - Each if_ready is spaced 6 cycles apart, with correct data per address.
- Reset asserted in the middle of a write:
  - sram_we/ce are 0 the following cycle; no mem_ready pulse; FSM in IDLE.
  - A new fetch issued afterwards completes normally.
- if_req rises during a mem ACCESS:
  - Fetch is not granted until after mem_ready.
  - if_ready is never coincident with mem_ready.
